// File: rtl/l1_intercon_pkg.sv
// Shared types and constants for the L1 trigger Wishbone interconnect.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package l1_intercon_pkg;

  localparam int ADR_W     = 15;
  localparam int SUB_ADR_W = 13;
  localparam int DAT_W     = 32;

  // Subspace index = wb_adr_i[14:13]
  localparam logic [1:0] SP_THRESH  = 2'd0;
  localparam logic [1:0] SP_CONTROL = 2'd1;
  localparam logic [1:0] SP_AGC     = 2'd2;
  localparam logic [1:0] SP_BQ      = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LOCAL  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/l1_intercon_sync.sv
// Two-flop synchronizer bringing the ifclk-running flag into the bus clock.
// Latency: 2 clk edges from d to q.
// Backpressure: none.
// Ports: clk, rst (async active-high), d (async level), q (synchronized level).
module l1_intercon_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/l1_trigger_wb_intercon.sv
// Wishbone 1-to-4 decoder splitting a 15-bit target port into four 13-bit subspaces.
// Latency: request sampled at edge 0, slave strobe from edge 1, upstream pulse one edge after the slave responds.
// Backpressure: one access outstanding; the upstream waits for ack/err/rty (timeout or local ack guarantee one).
// Ports: wb_* upstream target port; thresh_/control_/agc_/bq_* downstream masters;
//        clock_enabled_i is the asynchronous ifclk-running flag gating thresh and control.
module l1_trigger_wb_intercon
  import l1_intercon_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES      = 1023,
  parameter logic [DAT_W-1:0] DISABLED_READ_VALUE = 32'h0000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 clock_enabled_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [ADR_W-1:0]     wb_adr_i,
  input  logic [DAT_W-1:0]     wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  output logic [DAT_W-1:0]     wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o,
  output logic                 thresh_cyc_o,
  output logic                 thresh_stb_o,
  output logic                 thresh_we_o,
  output logic [SUB_ADR_W-1:0] thresh_adr_o,
  output logic [DAT_W-1:0]     thresh_dat_o,
  output logic [3:0]           thresh_sel_o,
  input  logic [DAT_W-1:0]     thresh_dat_i,
  input  logic                 thresh_ack_i,
  input  logic                 thresh_err_i,
  input  logic                 thresh_rty_i,
  output logic                 control_cyc_o,
  output logic                 control_stb_o,
  output logic                 control_we_o,
  output logic [SUB_ADR_W-1:0] control_adr_o,
  output logic [DAT_W-1:0]     control_dat_o,
  output logic [3:0]           control_sel_o,
  input  logic [DAT_W-1:0]     control_dat_i,
  input  logic                 control_ack_i,
  input  logic                 control_err_i,
  input  logic                 control_rty_i,
  output logic                 agc_cyc_o,
  output logic                 agc_stb_o,
  output logic                 agc_we_o,
  output logic [SUB_ADR_W-1:0] agc_adr_o,
  output logic [DAT_W-1:0]     agc_dat_o,
  output logic [3:0]           agc_sel_o,
  input  logic [DAT_W-1:0]     agc_dat_i,
  input  logic                 agc_ack_i,
  input  logic                 agc_err_i,
  input  logic                 agc_rty_i,
  output logic                 bq_cyc_o,
  output logic                 bq_stb_o,
  output logic                 bq_we_o,
  output logic [SUB_ADR_W-1:0] bq_adr_o,
  output logic [DAT_W-1:0]     bq_dat_o,
  output logic [3:0]           bq_sel_o,
  input  logic [DAT_W-1:0]     bq_dat_i,
  input  logic                 bq_ack_i,
  input  logic                 bq_err_i,
  input  logic                 bq_rty_i
);

  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT_CYCLES);

  logic                 en_s;
  state_t               state;
  logic [1:0]           sub_q;
  logic [SUB_ADR_W-1:0] adr_q;
  logic [DAT_W-1:0]     dat_q;
  logic                 we_q;
  logic [3:0]           sel_q;
  logic [3:0]           strobe_q;   // one-hot per subspace, drives cyc and stb
  logic [9:0]           tmo_cnt;

  logic [1:0]           sub_in;
  logic                 gated_in;
  logic [DAT_W-1:0]     rsp_dat;
  logic                 rsp_ack;
  logic                 rsp_err;
  logic                 rsp_rty;

  l1_intercon_sync u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d   (clock_enabled_i),
    .q   (en_s)
  );

  assign sub_in   = wb_adr_i[ADR_W-1:SUB_ADR_W];
  // Only thresh and control live in the ifclk domain.
  assign gated_in = (sub_in == SP_THRESH) || (sub_in == SP_CONTROL);

  // Only the selected slave's response is looked at; others are ignored.
  always_comb begin
    rsp_dat = thresh_dat_i;
    rsp_ack = 1'b0;
    rsp_err = 1'b0;
    rsp_rty = 1'b0;
    case (sub_q)
      SP_THRESH: begin
        rsp_dat = thresh_dat_i;
        rsp_ack = thresh_ack_i;
        rsp_err = thresh_err_i;
        rsp_rty = thresh_rty_i;
      end
      SP_CONTROL: begin
        rsp_dat = control_dat_i;
        rsp_ack = control_ack_i;
        rsp_err = control_err_i;
        rsp_rty = control_rty_i;
      end
      SP_AGC: begin
        rsp_dat = agc_dat_i;
        rsp_ack = agc_ack_i;
        rsp_err = agc_err_i;
        rsp_rty = agc_rty_i;
      end
      default: begin
        rsp_dat = bq_dat_i;
        rsp_ack = bq_ack_i;
        rsp_err = bq_err_i;
        rsp_rty = bq_rty_i;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      sub_q    <= SP_THRESH;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      strobe_q <= '0;
      tmo_cnt  <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            adr_q   <= wb_adr_i[SUB_ADR_W-1:0];
            dat_q   <= wb_dat_i;
            we_q    <= wb_we_i;
            sel_q   <= wb_sel_i;
            sub_q   <= sub_in;
            tmo_cnt <= '0;
            if (gated_in && !en_s) begin
              // ifclk is stopped: answer here so the pulse lands in LOCAL.
              state    <= LOCAL;
              wb_ack_o <= 1'b1;
              wb_dat_o <= DISABLED_READ_VALUE;
            end else begin
              state    <= ACCESS;
              strobe_q <= 4'(1) << sub_in;
            end
          end
        end
        ACCESS: begin
          if (!wb_cyc_i) begin
            strobe_q <= '0;
            state    <= IDLE;
          end else if (rsp_err || rsp_rty || rsp_ack) begin
            wb_dat_o <= rsp_dat;
            wb_err_o <= rsp_err;
            wb_rty_o <= !rsp_err && rsp_rty;
            wb_ack_o <= !rsp_err && !rsp_rty;
            strobe_q <= '0;
            state    <= DONE;
          end else if (tmo_cnt == TMO_LIMIT) begin
            wb_err_o <= 1'b1;
            wb_dat_o <= 32'hFFFF_FFFF;
            strobe_q <= '0;
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        LOCAL:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign thresh_cyc_o  = strobe_q[SP_THRESH];
  assign thresh_stb_o  = strobe_q[SP_THRESH];
  assign control_cyc_o = strobe_q[SP_CONTROL];
  assign control_stb_o = strobe_q[SP_CONTROL];
  assign agc_cyc_o     = strobe_q[SP_AGC];
  assign agc_stb_o     = strobe_q[SP_AGC];
  assign bq_cyc_o      = strobe_q[SP_BQ];
  assign bq_stb_o      = strobe_q[SP_BQ];

  // Captured request is broadcast; only the strobed slave acts on it.
  assign thresh_we_o   = we_q;
  assign thresh_adr_o  = adr_q;
  assign thresh_dat_o  = dat_q;
  assign thresh_sel_o  = sel_q;
  assign control_we_o  = we_q;
  assign control_adr_o = adr_q;
  assign control_dat_o = dat_q;
  assign control_sel_o = sel_q;
  assign agc_we_o      = we_q;
  assign agc_adr_o     = adr_q;
  assign agc_dat_o     = dat_q;
  assign agc_sel_o     = sel_q;
  assign bq_we_o       = we_q;
  assign bq_adr_o      = adr_q;
  assign bq_dat_o      = dat_q;
  assign bq_sel_o      = sel_q;

endmodule

// File: tb/tb_l1_trigger_wb_intercon.sv
// Directed bench for the L1 trigger Wishbone interconnect.
// Latency: cycle n is the interval starting 1 time unit after the n-th edge following request presentation.
// Backpressure: bench holds cyc/stb until it observes a termination pulse.
module tb_l1_trigger_wb_intercon;
  import l1_intercon_pkg::*;

  localparam logic [31:0] DIS_VAL = 32'hD15A_B1ED;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        clock_enabled_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [14:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o;

  logic        thresh_cyc_o, thresh_stb_o, thresh_we_o;
  logic [12:0] thresh_adr_o;
  logic [31:0] thresh_dat_o, thresh_dat_i;
  logic [3:0]  thresh_sel_o;
  logic        thresh_ack_i, thresh_err_i, thresh_rty_i;
  logic        control_cyc_o, control_stb_o, control_we_o;
  logic [12:0] control_adr_o;
  logic [31:0] control_dat_o, control_dat_i;
  logic [3:0]  control_sel_o;
  logic        control_ack_i, control_err_i, control_rty_i;
  logic        agc_cyc_o, agc_stb_o, agc_we_o;
  logic [12:0] agc_adr_o;
  logic [31:0] agc_dat_o, agc_dat_i;
  logic [3:0]  agc_sel_o;
  logic        agc_ack_i, agc_err_i, agc_rty_i;
  logic        bq_cyc_o, bq_stb_o, bq_we_o;
  logic [12:0] bq_adr_o;
  logic [31:0] bq_dat_o, bq_dat_i;
  logic [3:0]  bq_sel_o;
  logic        bq_ack_i, bq_err_i, bq_rty_i;

  int checks   = 0;
  int failures = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  l1_trigger_wb_intercon #(
    .TIMEOUT_CYCLES      (1023),
    .DISABLED_READ_VALUE (DIS_VAL)
  ) dut (
    .wb_clk_i, .wb_rst_i, .clock_enabled_i,
    .wb_cyc_i, .wb_stb_i, .wb_we_i, .wb_adr_i, .wb_dat_i, .wb_sel_i,
    .wb_dat_o, .wb_ack_o, .wb_err_o, .wb_rty_o,
    .thresh_cyc_o, .thresh_stb_o, .thresh_we_o, .thresh_adr_o, .thresh_dat_o, .thresh_sel_o,
    .thresh_dat_i, .thresh_ack_i, .thresh_err_i, .thresh_rty_i,
    .control_cyc_o, .control_stb_o, .control_we_o, .control_adr_o, .control_dat_o, .control_sel_o,
    .control_dat_i, .control_ack_i, .control_err_i, .control_rty_i,
    .agc_cyc_o, .agc_stb_o, .agc_we_o, .agc_adr_o, .agc_dat_o, .agc_sel_o,
    .agc_dat_i, .agc_ack_i, .agc_err_i, .agc_rty_i,
    .bq_cyc_o, .bq_stb_o, .bq_we_o, .bq_adr_o, .bq_dat_o, .bq_sel_o,
    .bq_dat_i, .bq_ack_i, .bq_err_i, .bq_rty_i
  );

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic req(input logic [14:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    wb_adr_i = adr;  wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
  endtask

  task automatic drop();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic quiet_slaves();
    thresh_ack_i = 0; thresh_err_i = 0; thresh_rty_i = 0; thresh_dat_i = 32'h1111_1111;
    control_ack_i = 0; control_err_i = 0; control_rty_i = 0; control_dat_i = 32'h2222_2222;
    agc_ack_i = 0; agc_err_i = 0; agc_rty_i = 0; agc_dat_i = 32'h3333_3333;
    bq_ack_i = 0; bq_err_i = 0; bq_rty_i = 0; bq_dat_i = 32'h4444_4444;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; clock_enabled_i = 1'b1;
    drop(); wb_we_i = 0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    quiet_slaves();
    tick(); tick();
    checks++; if ({thresh_cyc_o, control_cyc_o, agc_cyc_o, bq_cyc_o, thresh_stb_o, control_stb_o, agc_stb_o, bq_stb_o} !== 8'h00) begin failures++; $display("FAIL reset_strobes got=%b exp=0", {thresh_cyc_o, control_cyc_o, agc_cyc_o, bq_cyc_o}); end
    checks++; if ({wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o} !== 35'd0) begin failures++; $display("FAIL reset_upstream got ack=%b err=%b rty=%b dat=%h exp=0", wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o); end
    checks++; if ({bq_adr_o, bq_dat_o, bq_we_o, bq_sel_o} !== 50'd0) begin failures++; $display("FAIL reset_bcast got adr=%h dat=%h exp=0", bq_adr_o, bq_dat_o); end
    checks++; if (dut.en_s !== 1'b0) begin failures++; $display("FAIL reset_en_s got=%b exp=0", dut.en_s); end
    wb_rst_i = 1'b0;
    tick();
    checks++; if (dut.en_s !== 1'b0) begin failures++; $display("FAIL en_s_edge1 got=%b exp=0", dut.en_s); end
    tick();
    checks++; if (dut.en_s !== 1'b1) begin failures++; $display("FAIL en_s_edge2 got=%b exp=1", dut.en_s); end
  endtask

  task automatic test_read_control();
    req(15'h2004, 1'b0, 32'h0, 4'hF);
    agc_ack_i = 1'b1;  // stray response from an unselected slave
    tick();  // cycle 1
    checks++; if ({control_cyc_o, control_stb_o} !== 2'b11) begin failures++; $display("FAIL rd_ctrl_stb got=%b exp=11", {control_cyc_o, control_stb_o}); end
    checks++; if (control_adr_o !== 13'h0004) begin failures++; $display("FAIL rd_ctrl_adr got=%h exp=0004", control_adr_o); end
    checks++; if ({thresh_cyc_o, agc_cyc_o, bq_cyc_o, thresh_stb_o, agc_stb_o, bq_stb_o} !== 6'b0) begin failures++; $display("FAIL rd_others_idle got=%b exp=0", {thresh_cyc_o, agc_cyc_o, bq_cyc_o}); end
    tick();  // cycle 2
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL rd_stray_ack got=%b exp=0", wb_ack_o); end
    agc_ack_i = 1'b0;
    tick();  // cycle 3
    control_ack_i = 1'b1; control_dat_i = 32'h1234_5678;
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL rd_early_ack got=%b exp=0", wb_ack_o); end
    tick();  // cycle 4
    control_ack_i = 1'b0; drop();
    checks++; if (wb_ack_o !== 1'b1 || wb_err_o !== 1'b0) begin failures++; $display("FAIL rd_ack got ack=%b err=%b exp ack=1 err=0", wb_ack_o, wb_err_o); end
    checks++; if (wb_dat_o !== 32'h1234_5678) begin failures++; $display("FAIL rd_dat got=%h exp=12345678", wb_dat_o); end
    checks++; if (control_stb_o !== 1'b0) begin failures++; $display("FAIL rd_stb_drop got=%b exp=0", control_stb_o); end
    tick();
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL rd_ack_pulse got=%b exp=0", wb_ack_o); end
    tick();
  endtask

  task automatic test_abort();
    req(15'h2100, 1'b0, 32'h0, 4'hF);
    tick();  // cycle 1
    tick();  // cycle 2
    checks++; if (control_cyc_o !== 1'b1) begin failures++; $display("FAIL ab_cyc_held got=%b exp=1", control_cyc_o); end
    drop();
    tick();  // cycle 3
    checks++; if ({control_cyc_o, control_stb_o, wb_ack_o, wb_err_o, wb_rty_o} !== 5'b0) begin failures++; $display("FAIL ab_dropped got=%b exp=0", {control_cyc_o, control_stb_o, wb_ack_o, wb_err_o, wb_rty_o}); end
    control_ack_i = 1'b1;  // late answer to the aborted access
    req(15'h6000, 1'b0, 32'h0, 4'h3);
    tick();  // cycle 4
    control_ack_i = 1'b0;
    checks++; if (bq_stb_o !== 1'b1 || wb_ack_o !== 1'b0) begin failures++; $display("FAIL ab_next_stb got stb=%b ack=%b exp stb=1 ack=0", bq_stb_o, wb_ack_o); end
    checks++; if (bq_sel_o !== 4'h3) begin failures++; $display("FAIL ab_next_sel got=%h exp=3", bq_sel_o); end
    bq_ack_i = 1'b1; bq_dat_i = 32'hA5A5_0FF0;
    tick();  // cycle 5
    bq_ack_i = 1'b0; drop();
    checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'hA5A5_0FF0) begin failures++; $display("FAIL ab_next_ack got ack=%b dat=%h exp ack=1 dat=a5a50ff0", wb_ack_o, wb_dat_o); end
    tick(); tick();
  endtask

  task automatic test_err_priority_back_to_back();
    req(15'h4020, 1'b0, 32'h0, 4'hF);
    tick();  // cycle 1
    agc_err_i = 1'b1; agc_ack_i = 1'b1; agc_dat_i = 32'h0BAD_0BAD;
    tick();  // cycle 2: pulse visible, DUT in DONE
    agc_err_i = 1'b0; agc_ack_i = 1'b0;
    checks++; if ({wb_err_o, wb_rty_o, wb_ack_o} !== 3'b100) begin failures++; $display("FAIL prio_err got err/rty/ack=%b exp=100", {wb_err_o, wb_rty_o, wb_ack_o}); end
    checks++; if (wb_dat_o !== 32'h0BAD_0BAD) begin failures++; $display("FAIL prio_err_dat got=%h exp=0bad0bad", wb_dat_o); end
    req(15'h6004, 1'b1, 32'hCAFE_F00D, 4'hC);
    tick();  // cycle 3: IDLE, must not have captured during DONE
    checks++; if (bq_stb_o !== 1'b0 || agc_stb_o !== 1'b0) begin failures++; $display("FAIL b2b_no_recapture got bq=%b agc=%b exp 0", bq_stb_o, agc_stb_o); end
    tick();  // cycle 4
    checks++; if (bq_stb_o !== 1'b1 || bq_adr_o !== 13'h0004 || bq_dat_o !== 32'hCAFE_F00D || bq_we_o !== 1'b1) begin failures++; $display("FAIL b2b_capture got stb=%b adr=%h dat=%h we=%b exp 1/0004/cafef00d/1", bq_stb_o, bq_adr_o, bq_dat_o, bq_we_o); end
    bq_rty_i = 1'b1; bq_ack_i = 1'b1;
    tick();  // cycle 5
    bq_rty_i = 1'b0; bq_ack_i = 1'b0; drop();
    checks++; if ({wb_err_o, wb_rty_o, wb_ack_o} !== 3'b010) begin failures++; $display("FAIL prio_rty got err/rty/ack=%b exp=010", {wb_err_o, wb_rty_o, wb_ack_o}); end
    tick(); tick();
  endtask

  task automatic test_local();
    clock_enabled_i = 1'b0;
    tick(); tick(); tick();
    req(15'h0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
    tick();  // cycle 1
    drop();
    checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== DIS_VAL) begin failures++; $display("FAIL loc_ack got ack=%b dat=%h exp ack=1 dat=%h", wb_ack_o, wb_dat_o, DIS_VAL); end
    checks++; if (thresh_cyc_o !== 1'b0 || thresh_stb_o !== 1'b0) begin failures++; $display("FAIL loc_no_stb got cyc=%b stb=%b exp 0", thresh_cyc_o, thresh_stb_o); end
    tick();  // cycle 2
    checks++; if (wb_ack_o !== 1'b0 || thresh_stb_o !== 1'b0) begin failures++; $display("FAIL loc_pulse got ack=%b stb=%b exp 0", wb_ack_o, thresh_stb_o); end
    tick();
    req(15'h4010, 1'b1, 32'h0000_00AB, 4'h1);
    tick();  // cycle 1: agc is never gated
    checks++; if (agc_stb_o !== 1'b1 || agc_adr_o !== 13'h0010 || agc_dat_o !== 32'h0000_00AB || agc_we_o !== 1'b1 || agc_sel_o !== 4'h1) begin failures++; $display("FAIL loc_agc_stb got stb=%b adr=%h dat=%h exp 1/0010/000000ab", agc_stb_o, agc_adr_o, agc_dat_o); end
    checks++; if (wb_ack_o !== 1'b0) begin failures++; $display("FAIL loc_agc_noack got=%b exp=0", wb_ack_o); end
    agc_ack_i = 1'b1;
    tick();  // cycle 2: minimum latency
    agc_ack_i = 1'b0; drop();
    checks++; if (wb_ack_o !== 1'b1) begin failures++; $display("FAIL loc_agc_ack got=%b exp=1", wb_ack_o); end
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n;
    req(15'h7FFC, 1'b0, 32'h0, 4'hF);
    tick();  // cycle 1: bq cyc rises
    checks++; if (bq_cyc_o !== 1'b1) begin failures++; $display("FAIL tmo_cyc got=%b exp=1", bq_cyc_o); end
    n = 0;
    while (wb_err_o !== 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    drop();
    checks++; if (n != 1024) begin failures++; $display("FAIL tmo_cycles got=%0d exp=1024", n); end
    checks++; if (wb_dat_o !== 32'hFFFF_FFFF || wb_ack_o !== 1'b0) begin failures++; $display("FAIL tmo_dat got dat=%h ack=%b exp ffffffff/0", wb_dat_o, wb_ack_o); end
    checks++; if (bq_cyc_o !== 1'b0) begin failures++; $display("FAIL tmo_cyc_drop got=%b exp=0", bq_cyc_o); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_access();
    clock_enabled_i = 1'b1;
    tick(); tick(); tick();
    req(15'h2008, 1'b0, 32'h0, 4'hF);
    tick();  // cycle 1
    checks++; if (control_cyc_o !== 1'b1) begin failures++; $display("FAIL rst_pre_cyc got=%b exp=1", control_cyc_o); end
    #3 wb_rst_i = 1'b1;
    #1;
    checks++; if ({control_cyc_o, control_stb_o} !== 2'b00 || dut.state !== IDLE || dut.en_s !== 1'b0) begin failures++; $display("FAIL rst_mid got cyc=%b state=%0d en_s=%b exp 0/IDLE/0", control_cyc_o, dut.state, dut.en_s); end
    drop();
    tick();
    wb_rst_i = 1'b0;
    tick();
    checks++; if (dut.en_s !== 1'b0) begin failures++; $display("FAIL rst_en_s1 got=%b exp=0", dut.en_s); end
    tick();
    checks++; if (dut.en_s !== 1'b1) begin failures++; $display("FAIL rst_en_s2 got=%b exp=1", dut.en_s); end
  endtask

  initial begin
    test_reset();
    test_read_control();
    test_abort();
    test_err_priority_back_to_back();
    test_local();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
